uart_bridge: RTL and testbench

CPU-side client for the uart byte interface. Buffers outgoing bytes in a TX FIFO and sequences them into uart's tx_valid/tx_data/tx_complete handshake. Captures uart rx_complete/rx_data pulses into an RX FIFO. Exposes both FIFOs plus status and control through a small word-addressed register bus with an interrupt line.

---
 rtl/uart_bridge_pkg.sv | 26 ++
 rtl/uart_bridge_sync_fifo.sv | 60 ++++++
 rtl/uart_bridge.sv | 177 +++++++++++++++++
 tb/tb_uart_bridge.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared register map, STATUS/CTRL bit positions and TX sequencer state type
// for the uart bridge.
package uart_bridge_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int unsigned ST_RX_NOT_EMPTY = 0;
  localparam int unsigned ST_TX_NOT_FULL  = 1;
  localparam int unsigned ST_RX_OVERFLOW  = 2;
  localparam int unsigned ST_TX_IDLE      = 3;
  localparam int unsigned ST_TX_OVERFLOW  = 4;
  localparam int unsigned ST_RX_COUNT_LSB = 8;
  localparam int unsigned ST_TX_COUNT_LSB = 16;

  localparam int unsigned CTRL_RX_IRQ_EN = 0;
  localparam int unsigned CTRL_TX_IRQ_EN = 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY
  } tx_state_t;

endpackage

// File: rtl/uart_bridge_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_bridge.sv
// CPU register-bus client for the uart byte interface: TX/RX FIFOs, a TX
// launch sequencer, STATUS/CTRL registers and a level interrupt.
module uart_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter logic [31:0] RX_EMPTY_VALUE = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        irq,
  input  logic        rx_complete,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_complete
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          rd_req;
  logic          wr_req;
  logic          rd_data;
  logic          wr_data;
  logic          wr_status;
  logic          wr_ctrl;

  logic          rx_full;
  logic          rx_empty;
  logic          rx_pop;
  logic          rx_drop;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;

  logic          tx_full;
  logic          tx_empty;
  logic          tx_pop;
  logic          tx_drop;
  logic          tx_idle;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count;

  logic          rx_overflow;
  logic          tx_overflow;
  logic [1:0]    ctrl;
  logic [31:0]   status_word;
  logic [31:0]   rdata_next;
  tx_state_t     state;
  tx_state_t     state_next;
  logic          unused_wdata;

  assign rd_req    = cpu_req & ~cpu_write;
  assign wr_req    = cpu_req & cpu_write;
  assign rd_data   = rd_req & (cpu_addr == ADDR_DATA);
  assign wr_data   = wr_req & (cpu_addr == ADDR_DATA);
  assign wr_status = wr_req & (cpu_addr == ADDR_STATUS);
  assign wr_ctrl   = wr_req & (cpu_addr == ADDR_CTRL);

  assign rx_pop  = rd_data & ~rx_empty;
  assign rx_drop = rx_complete & rx_full & ~rx_pop;
  assign tx_drop = wr_data & tx_full & ~tx_pop;
  assign tx_idle = tx_empty & (state == IDLE);

  assign unused_wdata = ^cpu_wdata[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_complete),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_data),
    .push_data (cpu_wdata[7:0]),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // TX sequencer: state register / next state / outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!tx_empty) state_next = LAUNCH;
      LAUNCH:  state_next = BUSY;
      BUSY:    if (tx_complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_pop   = 1'b0;
    tx_valid = 1'b0;
    case (state)
      IDLE:    tx_pop   = ~tx_empty;
      LAUNCH:  tx_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_data <= '0;
    end else if (tx_pop) begin
      tx_data <= tx_head;
    end
  end

  always_comb begin
    status_word = {8'h00, 8'(tx_count), 8'(rx_count), 3'b000,
                   tx_overflow, tx_idle, rx_overflow, ~tx_full, ~rx_empty};
    rdata_next  = '0;
    if (rd_req) begin
      case (cpu_addr)
        ADDR_DATA:   rdata_next = rx_empty ? RX_EMPTY_VALUE : {24'h0, rx_head};
        ADDR_STATUS: rdata_next = status_word;
        ADDR_CTRL:   rdata_next = {30'h0, ctrl};
        default:     rdata_next = '0;
      endcase
    end
  end

  // A new overflow in the same cycle as its write-1-to-clear stays set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      irq         <= 1'b0;
      ctrl        <= '0;
      rx_overflow <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      cpu_ack   <= cpu_req;
      cpu_rdata <= rdata_next;
      irq       <= (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty) |
                   (ctrl[CTRL_TX_IRQ_EN] & tx_idle);
      if (wr_ctrl) begin
        ctrl <= cpu_wdata[1:0];
      end
      if (rx_drop) begin
        rx_overflow <= 1'b1;
      end else if (wr_status && cpu_wdata[ST_RX_OVERFLOW]) begin
        rx_overflow <= 1'b0;
      end
      if (tx_drop) begin
        tx_overflow <= 1'b1;
      end else if (wr_status && cpu_wdata[ST_TX_OVERFLOW]) begin
        tx_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_bridge.sv
// Bench for uart_bridge: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_bridge;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_write = 1'b0;
  logic [1:0]  cpu_addr = 2'd0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        irq;
  logic        rx_complete = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_complete = 1'b0;

  always #5 clock = ~clock;

  uart_bridge #(.DEPTH(DEPTH), .RX_EMPTY_VALUE(32'hFFFF_FFFF)) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .irq         (irq),
    .rx_complete (rx_complete),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_complete (tx_complete)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [7:0]  m_rxq[$];
  bit [7:0]  m_txq[$];
  bit        m_rx_ovf, m_tx_ovf;
  bit [1:0]  m_ctrl;
  bit        m_ack, m_irq;
  bit [31:0] m_rdata;
  bit        m_fly;          // a byte has left the FIFO and is not yet completed
  longint    m_edge, m_launch_edge;
  bit [7:0]  m_tx_data;

  function automatic bit m_tx_idle();
    return (m_txq.size() == 0) && !m_fly;
  endfunction

  function automatic bit [31:0] m_status();
    bit [31:0] s;
    s        = '0;
    s[0]     = m_rxq.size() != 0;
    s[1]     = m_txq.size() < DEPTH;
    s[2]     = m_rx_ovf;
    s[3]     = m_tx_idle();
    s[4]     = m_tx_ovf;
    s[15:8]  = 8'(m_rxq.size());
    s[23:16] = 8'(m_txq.size());
    return s;
  endfunction

  task automatic model_reset();
    m_rxq.delete();
    m_txq.delete();
    m_rx_ovf = 0; m_tx_ovf = 0; m_ctrl = 0;
    m_ack = 0; m_irq = 0; m_rdata = 0;
    m_fly = 0; m_edge = 0; m_launch_edge = -10; m_tx_data = 0;
  endtask

  task automatic model_step();
    bit rx_ne, rd, wd, ws, wc, tx_pop, done, rx_pop, tx_ok, rx_ok;
    bit [31:0] st;
    rx_ne = m_rxq.size() != 0;
    st    = m_status();
    m_edge++;
    rd = cpu_req && !cpu_write && cpu_addr == 2'd0;
    wd = cpu_req && cpu_write && cpu_addr == 2'd0;
    ws = cpu_req && cpu_write && cpu_addr == 2'd1;
    wc = cpu_req && cpu_write && cpu_addr == 2'd2;
    m_ack   = cpu_req;
    m_rdata = 0;
    if (cpu_req && !cpu_write) begin
      case (cpu_addr)
        2'd0:    m_rdata = rx_ne ? {24'h0, m_rxq[0]} : 32'hFFFF_FFFF;
        2'd1:    m_rdata = st;
        2'd2:    m_rdata = {30'h0, m_ctrl};
        default: m_rdata = 0;
      endcase
    end
    m_irq  = (m_ctrl[0] && rx_ne) || (m_ctrl[1] && m_tx_idle());
    // next byte leaves when nothing is in flight; completion counts only
    // from the second edge after the pop (the launch cycle ignores it)
    tx_pop = !m_fly && m_txq.size() != 0;
    done   = m_fly && tx_complete && (m_edge >= m_launch_edge + 2);
    rx_pop = rd && rx_ne;
    tx_ok  = wd && (m_txq.size() < DEPTH || tx_pop);
    rx_ok  = rx_complete && (m_rxq.size() < DEPTH || rx_pop);
    if (rx_pop) void'(m_rxq.pop_front());
    if (tx_pop) begin
      m_tx_data     = m_txq.pop_front();
      m_fly         = 1;
      m_launch_edge = m_edge;
    end
    if (done) m_fly = 0;
    if (tx_ok) m_txq.push_back(cpu_wdata[7:0]);
    if (rx_ok) m_rxq.push_back(rx_data);
    if (ws && cpu_wdata[2]) m_rx_ovf = 0;
    if (ws && cpu_wdata[4]) m_tx_ovf = 0;
    if (rx_complete && !rx_ok) m_rx_ovf = 1;
    if (wd && !tx_ok) m_tx_ovf = 1;
    if (wc) m_ctrl = cpu_wdata[1:0];
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // per-cycle comparison, 2 time units after the active edge
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (reset) begin
        check("ack", cpu_ack, m_ack);
        if (m_ack) check("rdata", cpu_rdata, m_rdata);
        check("tx_valid", tx_valid, m_fly && (m_launch_edge == m_edge));
        check("tx_data", tx_data, m_tx_data);
        check("irq", irq, m_irq);
      end
    end
  end

  // ---------------- uart responder / monitor ----------------
  bit       uart_stall = 0;
  bit       spurious_en = 0;
  bit [7:0] tx_seen[$];
  int       tx_valid_cycles = 0;

  initial begin
    int wait_n;
    bit pending;
    pending = 0;
    wait_n  = 0;
    forever begin
      @(negedge clock);
      tx_complete = 1'b0;
      if (!reset) begin
        pending = 0;
      end else if (tx_valid) begin
        tx_seen.push_back(tx_data);
        tx_valid_cycles++;
        pending = 1;
        wait_n  = int'($urandom_range(0, 4));
      end else if (pending) begin
        if (!uart_stall) begin
          if (wait_n == 0) begin
            tx_complete = 1'b1;
            pending     = 0;
          end else begin
            wait_n--;
          end
        end
      end else if (spurious_en && $urandom_range(0, 15) == 0) begin
        tx_complete = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus(input bit wr, input bit [1:0] addr, input bit [31:0] wd,
                     output bit [31:0] rd);
    @(negedge clock);
    cpu_req = 1'b1; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clock);
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = 2'd0; cpu_wdata = 32'h0;
    rd = cpu_rdata;
    check("bus_ack", cpu_ack, 1'b1);
  endtask

  task automatic rd_expect(input string name, input bit [1:0] addr, input bit [31:0] exp);
    bit [31:0] r;
    bus(1'b0, addr, 32'h0, r);
    check(name, r, exp);
  endtask

  task automatic wr(input bit [1:0] addr, input bit [31:0] wd);
    bit [31:0] r;
    bus(1'b1, addr, wd, r);
    check("wr_rdata_zero", r, 32'h0);
  endtask

  task automatic rx_byte(input bit [7:0] b);
    @(negedge clock);
    rx_complete = 1'b1; rx_data = b;
    @(negedge clock);
    rx_complete = 1'b0; rx_data = 8'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_tx_drain(input int budget);
    int i;
    for (i = 0; i < budget && !m_tx_idle(); i++) @(negedge clock);
    if (!m_tx_idle()) begin
      tests++; fails++;
      $display("FAIL tx_drain_timeout: got busy after %0d cycles, expected idle", budget);
    end
    idle(2);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit [31:0] r;

    idle(2);
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_ack", cpu_ack, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_tx_data", tx_data, 8'h0);
    @(negedge clock);
    reset = 1'b1;
    rd_expect("reset_status", 2'd1, 32'h0000_000A);
    rd_expect("reset_ctrl", 2'd2, 32'h0);
    rd_expect("reserved_read", 2'd3, 32'h0);

    // two bytes out
    tx_seen.delete(); tx_valid_cycles = 0;
    wr(2'd0, 32'h0000_0041);
    wr(2'd0, 32'hABCD_EF42);
    wait_tx_drain(200);
    check("tx_bytes_n", tx_seen.size(), 2);
    if (tx_seen.size() == 2) begin
      check("tx_byte0", tx_seen[0], 8'h41);
      check("tx_byte1", tx_seen[1], 8'h42);
    end
    check("tx_valid_width", tx_valid_cycles, 2);
    rd_expect("status_after_tx", 2'd1, 32'h0000_000A);

    // three bytes in, read back, then empty
    rx_byte(8'h10); rx_byte(8'h20); rx_byte(8'h30);
    rd_expect("status_rx3", 2'd1, 32'h0000_030B);
    rd_expect("rx_read0", 2'd0, 32'h10);
    rd_expect("rx_read1", 2'd0, 32'h20);
    rd_expect("rx_read2", 2'd0, 32'h30);
    rd_expect("rx_read_empty", 2'd0, 32'hFFFF_FFFF);

    // RX overflow
    for (int i = 0; i < 17; i++) rx_byte(8'(8'h50 + i));
    rd_expect("status_rx_ovf", 2'd1, 32'h0000_100F);
    for (int i = 0; i < 16; i++) rd_expect("rx_ovf_read", 2'd0, 32'(8'h50 + i));
    rd_expect("rx_17th_absent", 2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'h0000_0004);
    rd_expect("status_rx_ovf_clr", 2'd1, 32'h0000_000A);

    // TX overflow with a stalled uart
    tx_seen.delete();
    uart_stall = 1;
    for (int i = 0; i < 17; i++) wr(2'd0, 32'(8'h60 + i));
    idle(3);
    rd_expect("status_tx_full", 2'd1, 32'h0010_0000);
    wr(2'd0, 32'h0000_00EE);
    rd_expect("status_tx_ovf", 2'd1, 32'h0010_0010);
    wr(2'd1, 32'h0000_0010);
    rd_expect("status_tx_ovf_clr", 2'd1, 32'h0010_0000);
    uart_stall = 0;
    wait_tx_drain(1000);
    check("tx_stall_bytes_n", tx_seen.size(), 17);
    for (int i = 0; i < tx_seen.size() && i < 17; i++)
      check("tx_stall_byte", tx_seen[i], 8'(8'h60 + i));

    // RX interrupt
    wr(2'd2, 32'h0000_0001);
    rx_byte(8'h77);
    idle(2);
    check("irq_rx_set", irq, 1'b1);
    bus(1'b0, 2'd0, 32'h0, r);
    check("irq_read_byte", r, 32'h77);
    check("irq_during_ack", irq, 1'b1);
    @(negedge clock);
    check("irq_cleared", irq, 1'b0);
    wr(2'd2, 32'h0000_0002);
    idle(2);
    check("irq_tx_idle", irq, 1'b1);
    wr(2'd2, 32'h0);

    // randomized traffic
    spurious_en = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      cpu_req   = ($urandom_range(0, 99) < 40);
      cpu_write = 1'($urandom_range(0, 1));
      if (c < 2000) cpu_addr = 2'($urandom_range(0, 3));
      else          cpu_addr = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
      cpu_wdata   = $urandom;
      rx_complete = ($urandom_range(0, 99) < ((c < 2000) ? 30 : 10));
      rx_data     = 8'($urandom);
    end
    @(negedge clock);
    cpu_req = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    rx_complete = 0; rx_data = 0;
    spurious_en = 0;
    wait_tx_drain(1000);

    // reset while a byte is in flight
    uart_stall = 1;
    wr(2'd0, 32'h0000_0099);
    for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clock);
    idle(2);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 2'd1;
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 1'b0);
    check("midrst_ack", cpu_ack, 1'b0);
    check("midrst_tx_data", tx_data, 8'h0);
    cpu_req = 1'b0;
    uart_stall = 0;
    idle(3);
    reset = 1'b1;
    rd_expect("status_after_rst", 2'd1, 32'h0000_000A);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
